// File: rtl/vram_access_arbiter.sv
// Single-port tile-map RAM arbiter: VGA scan-out owns active p_tick cycles, requesters share the rest round-robin.
// Optional macro VRAM_ARB_BLANK_ONLY_WR_EN restricts writes to blanking (display_on=0).
module vram_access_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 12,
    parameter int NREQ       = 4,
    parameter int TILE_SHIFT = 4,
    parameter int MAP_COLS   = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     p_tick,
    input  logic                     display_on,
    input  logic [9:0]               x,
    input  logic [9:0]               y,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [DATA_W-1:0]        pix_tile,
    output logic                     pix_valid,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t            r_state;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [NREQ-1:0]   r_rvalid;
    logic              r_pix_valid;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_pix_tile;

    logic              w_run;
    logic              w_disp_slot;
    logic              w_free_slot;
    logic              w_hit;
    logic [NREQ-1:0]   w_elig;
    logic [PTR_W-1:0]  w_win;
    int unsigned       w_idx;
    logic [ADDR_W-1:0] w_disp_addr;

    assign w_run       = (r_state == S_RUN);
    assign w_disp_slot = w_run & p_tick & display_on;
    assign w_free_slot = w_run & ~(p_tick & display_on);
    assign w_disp_addr = ADDR_W'(((32'(y) >> TILE_SHIFT) * MAP_COLS) + (32'(x) >> TILE_SHIFT));

    always_comb begin
`ifdef VRAM_ARB_BLANK_ONLY_WR_EN
        // Writes during active video are invisible to the search, so rr_ptr never parks on them.
        w_elig = req & ~(req_we & {NREQ{display_on}});
`else
        w_elig = req;
`endif
    end

    always_comb begin
        w_hit = 1'b0;
        w_win = '0;
        w_idx = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = (32'(r_rr_ptr) + k) % unsigned'(NREQ);
            if (!w_hit && w_elig[PTR_W'(w_idx)]) begin
                w_hit = 1'b1;
                w_win = PTR_W'(w_idx);
            end
        end
    end

    always_comb begin
        gnt       = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_disp_slot) begin
            mem_en   = 1'b1;
            mem_addr = w_disp_addr;
        end else if (w_free_slot && w_hit) begin
            gnt[w_win] = 1'b1;
            mem_en     = 1'b1;
            mem_we     = req_we[w_win];
            mem_addr   = req_addr[w_win*ADDR_W +: ADDR_W];
            mem_wdata  = req_wdata[w_win*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_rvalid    <= '0;
            r_pix_valid <= 1'b0;
            r_rdata     <= '0;
            r_pix_tile  <= '0;
        end else begin
            r_rvalid    <= gnt & ~req_we;
            r_pix_valid <= w_disp_slot;
            if (|r_rvalid) begin
                r_rdata <= mem_rdata;
            end
            if (r_pix_valid) begin
                r_pix_tile <= mem_rdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (p_tick) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_free_slot && w_hit) begin
                        r_rr_ptr <= (w_win == PTR_W'(NREQ - 1)) ? '0 : w_win + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM data arrives one cycle after the access; present it live on the valid cycle, hold it afterwards.
    assign rvalid    = r_rvalid;
    assign pix_valid = r_pix_valid;
    assign rdata     = (|r_rvalid) ? mem_rdata : r_rdata;
    assign pix_tile  = r_pix_valid ? mem_rdata : r_pix_tile;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Scoreboard bench for vram_access_arbiter: stimulus queues expected grants/reads/tiles, a monitor pops and compares.
module tb_vram_access_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 12;
    localparam int NREQ   = 4;

    logic                   clk;
    logic                   reset;
    logic                   p_tick;
    logic                   display_on;
    logic [9:0]             x;
    logic [9:0]             y;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [DATA_W-1:0]      rdata;
    logic [DATA_W-1:0]      pix_tile;
    logic                   pix_valid;
    logic                   mem_en;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;

    vram_access_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NREQ(NREQ),
        .TILE_SHIFT(4),
        .MAP_COLS(40)
    ) dut (
        .clk(clk),
        .reset(reset),
        .p_tick(p_tick),
        .display_on(display_on),
        .x(x),
        .y(y),
        .req(req),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .gnt(gnt),
        .rvalid(rvalid),
        .rdata(rdata),
        .pix_tile(pix_tile),
        .pix_valid(pix_valid),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int exp_gnt[$];
    int exp_rd_id[$];
    logic [7:0] exp_rd_dat[$];
    logic [7:0] exp_pix[$];
    logic [NREQ-1:0] g_seen;
    bit auto_drop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic half();
        @(negedge clk);
        g_seen = gnt;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        if (auto_drop) req = req & ~g_seen;
        g_seen = '0;
    endtask

    task automatic step();
        half();
        adv();
    endtask

    task automatic set_vid(input logic pt, input logic de, input logic [9:0] xx, input logic [9:0] yy);
        p_tick = pt;
        display_on = de;
        x = xx;
        y = yy;
    endtask

    task automatic set_req(input int i, input logic we, input logic [11:0] a, input logic [7:0] d);
        req[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic push_rd(input int i, input logic [7:0] d);
        exp_gnt.push_back(i);
        exp_rd_id.push_back(i);
        exp_rd_dat.push_back(d);
    endtask

    // Monitor: every presented grant, read return and tile fetch must match the next queued expectation.
    initial begin
        int e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (gnt != '0) begin
                if (exp_gnt.size() == 0) chk("gnt_unexpected", 32'(gnt), 0);
                else begin
                    e = exp_gnt.pop_front();
                    chk("gnt_order", 32'(gnt), 32'(1) << e);
                end
            end
            if (rvalid != '0) begin
                if (exp_rd_id.size() == 0) chk("rvalid_unexpected", 32'(rvalid), 0);
                else begin
                    e = exp_rd_id.pop_front();
                    chk("rvalid_id", 32'(rvalid), 32'(1) << e);
                    chk("rdata", 32'(rdata), 32'(exp_rd_dat.pop_front()));
                end
            end
            if (pix_valid === 1'b1) begin
                if (exp_pix.size() == 0) chk("pix_unexpected", 32'(pix_valid), 0);
                else chk("pix_tile", 32'(pix_tile), 32'(exp_pix.pop_front()));
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
        ram[0]  = 8'h0F;
        ram[11] = 8'hA1;
        ram[12] = 8'hA2;
        ram[13] = 8'hA3;
        ram[14] = 8'hA4;
        ram[15] = 8'hA5;
        ram[42] = 8'h5A;
        mem_rdata = '0;
        reset = 1'b1;
        req = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        g_seen = '0;
        auto_drop = 1'b1;
        set_vid(1'b0, 1'b0, 10'd0, 10'd0);
        set_req(3, 1'b0, 12'd11, 8'h00);

        // Reset held, then idle until the first p_tick
        repeat (3) adv();
        half();
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_rvalid", 32'(rvalid), 0);
        chk("reset_pix_valid", 32'(pix_valid), 0);
        chk("reset_mem", {mem_en, mem_we, 30'(mem_addr)}, 0);
        chk("reset_data", {mem_wdata, rdata, pix_tile}, 0);
        adv();
        reset = 1'b0;
        repeat (2) begin
            half();
            chk("idle_no_gnt", 32'(gnt), 0);
            adv();
        end
        set_vid(1'b1, 1'b0, 10'd0, 10'd0);
        half();
        chk("idle_ptick_no_gnt", 32'(gnt), 0);
        adv();
        push_rd(3, 8'hA1);
        set_vid(1'b0, 1'b0, 10'd0, 10'd0);
        step();
        half();
        chk("rvalid_timing", 32'(rvalid), 32'h8);
        adv();

        // Display fetch: (x=35,y=20) -> cell (1,2) -> addr 42
        set_vid(1'b1, 1'b1, 10'd35, 10'd20);
        exp_pix.push_back(8'h5A);
        half();
        chk("disp_addr", 32'(mem_addr), 42);
        chk("disp_en_rd", {30'd0, mem_en, mem_we}, 32'h2);
        chk("disp_no_gnt", 32'(gnt), 0);
        adv();
        set_vid(1'b0, 1'b1, 10'd35, 10'd20);
        step();
        half();
        chk("pix_hold", {23'd0, pix_valid, pix_tile}, 32'h05A);
        adv();

        // Held reads during blanking: 0,1,2,3,0
        auto_drop = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 12'(12 + i), 8'h00);
        push_rd(0, 8'hA2);
        push_rd(1, 8'hA3);
        push_rd(2, 8'hA4);
        push_rd(3, 8'hA5);
        push_rd(0, 8'hA2);
        for (int k = 0; k < 5; k++) begin
            set_vid(1'(k & 1), 1'b0, 10'd0, 10'd0);
            step();
        end
        req = '0;
        half();
        chk("rvalid_last", 32'(rvalid), 32'h1);
        adv();
        half();
        chk("rdata_hold", {23'd0, |rvalid, rdata}, 32'h0A2);
        adv();
        auto_drop = 1'b1;

        // Write coincident with display slot waits one cycle
        set_vid(1'b1, 1'b1, 10'd0, 10'd0);
        set_req(2, 1'b1, 12'd100, 8'h33);
        exp_pix.push_back(8'h0F);
        half();
        chk("disp_wins", 32'(gnt), 0);
        chk("disp_wins_we", 32'(mem_we), 0);
        adv();
        exp_gnt.push_back(2);
        set_vid(1'b0, 1'b1, 10'd0, 10'd0);
        half();
        chk("wr_addr", 32'(mem_addr), 100);
        chk("wr_data", {mem_we, 31'(mem_wdata)}, 32'h80000033);
        adv();
        set_vid(1'b0, 1'b0, 10'd0, 10'd0);
        half();
        chk("wr_no_rvalid", 32'(rvalid), 0);
        adv();
        set_req(2, 1'b0, 12'd100, 8'h00);
        push_rd(2, 8'h33);
        step();
        step();

        // Write in active video vs read in same window
        set_vid(1'b1, 1'b1, 10'd0, 10'd0);
        set_req(1, 1'b1, 12'd200, 8'h77);
        set_req(3, 1'b0, 12'd13, 8'h00);
        repeat (3) exp_pix.push_back(8'h0F);
        push_rd(3, 8'hA3);
        exp_gnt.push_back(1);
        step();
        set_vid(1'b0, 1'b1, 10'd0, 10'd0);
        half();
        chk("rd_in_video", 32'(gnt), 32'h8);
        adv();
        set_vid(1'b1, 1'b1, 10'd0, 10'd0);
        step();
        set_vid(1'b0, 1'b1, 10'd0, 10'd0);
        half();
`ifdef VRAM_ARB_BLANK_ONLY_WR_EN
        chk("wr_blocked", 32'(gnt), 0);
`else
        chk("wr_first_free", 32'(gnt), 32'h2);
`endif
        adv();
        set_vid(1'b1, 1'b1, 10'd0, 10'd0);
        step();
        set_vid(1'b0, 1'b1, 10'd0, 10'd0);
        half();
        chk("wr_still_blocked", 32'(gnt), 0);
        adv();
        set_vid(1'b1, 1'b0, 10'd0, 10'd0);
        half();
`ifdef VRAM_ARB_BLANK_ONLY_WR_EN
        chk("wr_in_blank", 32'(gnt), 32'h2);
`else
        chk("wr_done_before_blank", 32'(gnt), 0);
`endif
        adv();
        step();

        // Reset right after a read grant cancels the return and rewinds rr_ptr
        set_vid(1'b0, 1'b0, 10'd0, 10'd0);
        set_req(2, 1'b0, 12'd14, 8'h00);
        exp_gnt.push_back(2);
        half();
        chk("pre_reset_gnt", 32'(gnt), 32'h4);
        reset = 1'b1;
        adv();
        half();
        chk("reset_cancel", {30'd0, |rvalid, pix_valid}, 0);
        chk("reset_rdata", 32'(rdata), 0);
        adv();
        reset = 1'b0;
        set_req(1, 1'b0, 12'd12, 8'h00);
        set_req(3, 1'b0, 12'd15, 8'h00);
        set_vid(1'b1, 1'b0, 10'd0, 10'd0);
        half();
        chk("post_reset_idle", 32'(gnt), 0);
        adv();
        push_rd(1, 8'hA2);
        push_rd(3, 8'hA5);
        set_vid(1'b0, 1'b0, 10'd0, 10'd0);
        half();
        chk("post_reset_first", 32'(gnt), 32'h2);
        adv();
        set_vid(1'b1, 1'b0, 10'd0, 10'd0);
        step();
        set_vid(1'b0, 1'b0, 10'd0, 10'd0);
        repeat (3) step();

        chk("gnt_q_drained", 32'(exp_gnt.size()), 0);
        chk("rd_q_drained", 32'(exp_rd_id.size()), 0);
        chk("pix_q_drained", 32'(exp_pix.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
